// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs the busy countdown, owns HI/LO.
// Optional build macro MD_ZERO_SKIP_EN: multiplies with a zero operand finish after a single busy cycle.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    sh_q, sh_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        div_by, quot_u, rem_u;
    logic signed [31:0] quot_s, rem_s;
    logic [CW-1:0]      mul_n;

    // Datapath; a zero divisor is replaced by 1 so the result is defined (it is discarded anyway).
    always_comb begin
        div_by = (rt_val == 32'd0) ? 32'd1 : rt_val;
        prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        quot_s = $signed(rs_val) / $signed(div_by);
        rem_s  = $signed(rs_val) % $signed(div_by);
        quot_u = rs_val / div_by;
        rem_u  = rs_val % div_by;
`ifdef MD_ZERO_SKIP_EN
        mul_n  = (rs_val == 32'd0 || rt_val == 32'd0) ? CW'(1) : MULT_N;
`else
        mul_n  = MULT_N;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            sh_d    = (md_op == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = mul_n;
                            dz_d    = 1'b0;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            sh_d    = (md_op == OP_DIV) ? {32'($unsigned(rem_s)), 32'($unsigned(quot_s))}
                                                        : {rem_u, quot_u};
                            cnt_d   = DIV_N;
                            dz_d    = (rt_val == 32'd0);
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    if (!dz_q) begin
                        hi_d = sh_q[63:32];
                        lo_d = sh_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: vector table with scoreboard queue plus hand-written corner sequences.
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

`ifdef MD_ZERO_SKIP_EN
    localparam int ZMUL = 1;
`else
    localparam int ZMUL = 5;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, ehi, elo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] ehi, elo;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Issue one op at cycle T; optionally inject a second start at cycle T+inj while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n,
                          input int inj, input logic [2:0] inj_op, input logic [31:0] inj_rs);
        exp_t e;
        logic [31:0] pre_hi, pre_lo;
        int cnt, cyc;
        @(negedge clk);
        pre_hi = hi; pre_lo = lo;
        start = 1'b1; md_op = op; rs_val = rs; rt_val = rt;
        sb.push_back('{ehi, elo, n});
        @(negedge clk);
        start = 1'b0; md_op = 3'd0; rs_val = $urandom; rt_val = $urandom;
        if (n == 0) begin
            e = sb.pop_front();
            chk("mt_busy", 32'(busy), 32'd0);
            chk("mt_done", 32'(done), 32'd0);
            chk("mt_hi", hi, e.ehi);
            chk("mt_lo", lo, e.elo);
            return;
        end
        cnt = 0; cyc = 1;
        while (!done && cyc < 40) begin
            if (busy) cnt++;
            chk("hold_hi", hi, pre_hi);
            chk("hold_lo", lo, pre_lo);
            if (cyc == inj) begin
                start = 1'b1; md_op = inj_op; rs_val = inj_rs;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; md_op = 3'd0;
        e = sb.pop_front();
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_cycles", 32'(cnt), 32'(e.n));
        chk("done_cycle", 32'(cyc), 32'(e.n + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("res_hi", hi, e.ehi);
        chk("res_lo", lo, e.elo);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    vec_t vt[14];

    initial begin
        logic [63:0] p;
        logic [31:0] a, b;
        int seen_done;

        vt[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'hFFFFFFFD, 0};
        vt[4]  = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        vt[5]  = '{3'd4, 32'd100,      32'd0,        32'h00000011, 32'h00000022, 10};
        vt[6]  = '{3'd0, 32'h5,        32'h5,        32'h00000011, 32'h00000022, 0};
        vt[7]  = '{3'd7, 32'h5,        32'h5,        32'h00000011, 32'h00000022, 0};
        vt[8]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vt[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vt[10] = '{3'd1, 32'd0,        32'd7,        32'h00000000, 32'h00000000, ZMUL};
        vt[11] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vt[12] = '{3'd3, 32'h80000000, 32'd0,        32'h00000001, 32'h00000000, 10};
        vt[13] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

        reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;

        foreach (vt[i])
            run_op(vt[i].op, vt[i].rs, vt[i].rt, vt[i].ehi, vt[i].elo, vt[i].n, 0, 3'd0, 32'd0);

        for (int i = 0; i < 4; i++) begin
            a = $urandom | 32'd1; b = $urandom | 32'd1;
            p = {32'd0, a} * {32'd0, b};
            run_op(3'd2, a, b, p[63:32], p[31:0], 5, 0, 3'd0, 32'd0);
        end

        // MTHI while busy must be ignored.
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 2, 3'd5, 32'h0000ABCD);
        // A second MULT start while busy must not restart the countdown.
        run_op(3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5, 3, 3'd2, 32'd9);

        // Reset asserted in T+4 of a DIV: immediate abort, no done afterwards.
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; rs_val = 32'd50; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        chk("no_done_after_abort", 32'(seen_done), 32'd0);
        chk("post_abort_hi", hi, 32'd0);

        run_op(3'd2, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0, 3'd0, 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
